// File: rtl/stream_divider_core.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done level handshake.
// Results are registered and change only when a division completes.
module stream_divider_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] reminder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] dvd_r, dvd_next_s;
    logic [WIDTH-1:0] dvs_r, dvs_next_s;
    logic [WIDTH:0]   rem_r, rem_next_s;
    logic [CW-1:0]    cnt_r, cnt_next_s;
    logic [WIDTH-1:0] quo_r, quo_next_s;
    logic [WIDTH-1:0] rmd_r, rmd_next_s;
    logic             done_r, done_next_s;
    logic [2*WIDTH:0] step_s;

    // One restoring step: returns {partial remainder (WIDTH+1), shifted quotient (WIDTH)}.
    function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   rem,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] dext;
        shifted = {rem[WIDTH-1:0], q[WIDTH-1]};
        dext    = {1'b0, d};
        if (shifted >= dext) begin
            div_step = {shifted - dext, q[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {shifted, q[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Next-state and datapath update for the IDLE/BUSY/DONE handshake.
    always_comb begin
        state_next_s = state_r;
        dvd_next_s   = dvd_r;
        dvs_next_s   = dvs_r;
        rem_next_s   = rem_r;
        cnt_next_s   = cnt_r;
        quo_next_s   = quo_r;
        rmd_next_s   = rmd_r;
        done_next_s  = done_r;
        step_s       = div_step(rem_r, dvd_r, dvs_r);
        case (state_r)
            IDLE: begin
                done_next_s = 1'b0;
                if (start) begin
                    dvd_next_s   = dividend;
                    dvs_next_s   = divisor;
                    rem_next_s   = {(WIDTH + 1){1'b0}};
                    cnt_next_s   = CNT_INIT;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                // dvd_r doubles as the quotient shift register while busy
                rem_next_s = step_s[2*WIDTH:WIDTH];
                dvd_next_s = step_s[WIDTH-1:0];
                cnt_next_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_next_s = DONE;
                    done_next_s  = 1'b1;
                    quo_next_s   = step_s[WIDTH-1:0];
                    rmd_next_s   = step_s[2*WIDTH-1:WIDTH];
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (!start) begin
                    state_next_s = IDLE;
                    done_next_s  = 1'b0;
                end else begin
                    state_next_s = DONE;
                    done_next_s  = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
                done_next_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any division in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            dvd_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            rem_r   <= {(WIDTH + 1){1'b0}};
            cnt_r   <= {CW{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            rmd_r   <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            dvd_r   <= dvd_next_s;
            dvs_r   <= dvs_next_s;
            rem_r   <= rem_next_s;
            cnt_r   <= cnt_next_s;
            quo_r   <= quo_next_s;
            rmd_r   <= rmd_next_s;
            done_r  <= done_next_s;
        end
    end

    assign done     = done_r;
    assign quotient = quo_r;
    assign reminder = rmd_r;

endmodule

// File: tb/tb_stream_divider_core.sv
// Scoreboard bench for stream_divider_core: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done rises.
module tb_stream_divider_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] reminder;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_r[$];
    logic        prev_done = 1'b0;

    stream_divider_core #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .done     (done),
        .quotient (quotient),
        .reminder (reminder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every rising done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%h/%h required=none", quotient, reminder);
            end else begin
                check32("sb_quotient", quotient, exp_q.pop_front());
                check32("sb_reminder", reminder, exp_r.pop_front());
            end
        end
        prev_done = done;
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input bit scramble, input int hold);
        int n;
        exp_q.push_back(eq);
        exp_r.push_back(er);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (scramble) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check32("latency", n, 32);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check32("hold_done", {31'd0, done}, 32'd1);
            check32("hold_quotient", quotient, eq);
            check32("hold_reminder", reminder, er);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check32("release_done", {31'd0, done}, 32'd0);
        check32("release_quotient", quotient, eq);
        check32("release_reminder", reminder, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(negedge clk);
        check32("reset_done", {31'd0, done}, 32'd0);
        check32("reset_quotient", quotient, 32'd0);
        check32("reset_reminder", reminder, 32'd0);
        reset = 1'b1;

        run_div(32'd30, 32'd7, 32'd4, 32'd2, 1'b0, 0);
        run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
        run_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 0);
        run_div(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 10);
        run_div(32'd100, 32'd9, 32'd11, 32'd1, 1'b0, 0);

        // Abort a division mid-flight with an asynchronous reset.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check32("abort_done", {31'd0, done}, 32'd0);
        check32("abort_quotient", quotient, 32'd0);
        check32("abort_reminder", reminder, 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_div(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 0);
        run_div(32'd81, 32'd9, 32'd9, 32'd0, 1'b1, 0);

        repeat (3) @(negedge clk);
        check32("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
